pmc_pm_ctrl_seq: RTL and testbench
==================================

// Module: pmc_pm_ctrl_seq
// PURPOSE
//  Programmable acquisition sequencer driving the pixel-matrix control bundle
//  (res, gate, strobe, store, sh_a, sh_b, clk_sh) from the SoC PMC.
//  Runs one frame per start pulse: GATE -> STROBE -> STORE -> SHIFT.
//  Sits between the PMC register file (cfg_*, start/abort) and the matrix pads.
//  Generalises the fixed 10-bit res bundle to RES_W and adds a timed clk_sh generator.
// PARAMETERS
//  RES_W   10  width of res (pixel reset/trim config bus)
//  CNT_W   16  width of gate/strobe/shift length counters
//  DIV_W   8   width of clk_sh half-period divider
// PORTS
//  clk           in   1      system clock
//  rst           in   1      async active-high reset
//  start         in   1      1-cycle request to run a frame; ignored unless IDLE
//  abort         in   1      terminate frame; priority over start
//  cfg_res       in   RES_W  res value applied for the frame
//  cfg_gate_len  in   CNT_W  gate high cycles (0 treated as 1)
//  cfg_strb_len  in   CNT_W  strobe high cycles (0 skips STROBE)
//  cfg_shift_len in   CNT_W  number of clk_sh pulses (0 skips SHIFT)
//  cfg_clk_div   in   DIV_W  clk_sh half-period = cfg_clk_div+1 cycles
//  cfg_sh_sel    in   2      {sh_a,sh_b} levels during SHIFT
//  cfg_repeat    in   8      extra frames after first (only with macro)
//  busy          out  1      state != IDLE
//  done          out  1      1-cycle pulse on completion of final frame
//  res           out  RES_W  matrix res bus
//  gate,strobe,store,sh_a,sh_b,clk_sh  out 1 each  matrix control lines
// BEHAVIOUR
//  - One clock domain; rst async active-high. All outputs registered; reset value 0 for
//    every output incl. res, busy, done.
//  - FSM: IDLE, GATE, STROBE, STORE, SHIFT, DONE.
//  - IDLE: start=1 & abort=0 -> latch all cfg_* into shadow regs; res <= cfg_res;
//    next state GATE. cfg_* changes after latch have no effect on running frame.
//  - Latency: start sampled at cycle N -> gate=1 and busy=1 at cycle N+1.
//  - GATE: gate=1 for max(cfg_gate_len,1) cycles -> STROBE (or STORE if strb_len=0).
//  - STROBE: strobe=1 for cfg_strb_len cycles -> STORE.
//  - STORE: store=1 exactly 1 cycle -> SHIFT (or DONE if shift_len=0).
//  - SHIFT: sh_a/sh_b = shadow cfg_sh_sel, held constant whole state; clk_sh starts high,
//    alternates high/low each (cfg_clk_div+1) cycles; cfg_shift_len full pulses; state
//    ends after last low phase. sh_a/sh_b/clk_sh = 0 in every other state.
//  - DONE: done=1, busy=1 one cycle -> IDLE. gate/strobe/store/clk_sh never overlap.
//  - res holds latched value after frame ends until next start or reset.
//  - abort in any non-IDLE state: next cycle state=IDLE, gate/strobe/store/sh_a/sh_b/
//    clk_sh/busy=0, no done pulse, res held. abort+start same cycle in IDLE: no frame.
//  - start while busy: ignored, not queued.
//  - Counters count down from loaded length; no wrap: max lengths 2^CNT_W-1, 2^DIV_W.
//  - rst mid-frame: all outputs 0 immediately (async), FSM IDLE, shadow regs cleared.
// CONFIGURATION
//  PMC_PM_CTRL_SEQ_REPEAT_EN defined: cfg_repeat port present; SHIFT (or STORE if
//    shift_len=0) end returns to GATE while repeat counter>0 (decrement each loop), res
//    unchanged between frames, no done between frames; done only after final frame.
//    abort also clears the repeat counter.
//  Undefined: cfg_repeat port absent; exactly one frame per start.
// TESTING
//  1. gate=3,strb=2,shift=4,div=0,sh_sel=2'b10,start@0 -> gate 1-3, strobe 4-5, store 6,
//     clk_sh high 7,9,11,13, sh_a=1/sh_b=0 7-14, done@15, busy 1-15.
//  2. gate=0,strb=0,shift=0 -> gate@1 only, store@2, done@3; no strobe/clk_sh activity.
//  3. div=2, shift=2 -> clk_sh high 3 cycles/low 3 cycles x2; cfg change mid-frame ignored.
//  4. abort during SHIFT -> all lines 0 next cycle, busy 0, no done; start during busy ignored.
//  5. rst asserted mid-GATE -> all outputs 0 same cycle; res=0; new start runs normally.
//  6. (REPEAT_EN) repeat=2 -> three gate pulses, res constant, single done after third frame.

Source files
------------

// File: rtl/pmc_pm_ctrl_seq.sv
// pmc_pm_ctrl_seq: programmable acquisition sequencer for the pixel-matrix
// control bundle. One frame per start pulse: GATE -> STROBE -> STORE -> SHIFT.
// Optional build macro PMC_PM_CTRL_SEQ_REPEAT_EN adds the cfg_repeat port and
// back-to-back frame repetition with a single done after the last frame.
module pmc_pm_ctrl_seq #(
    parameter int RES_W = 10,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [RES_W-1:0] cfg_res,
    input  logic [CNT_W-1:0] cfg_gate_len,
    input  logic [CNT_W-1:0] cfg_strb_len,
    input  logic [CNT_W-1:0] cfg_shift_len,
    input  logic [DIV_W-1:0] cfg_clk_div,
    input  logic [1:0]       cfg_sh_sel,
`ifdef PMC_PM_CTRL_SEQ_REPEAT_EN
    input  logic [7:0]       cfg_repeat,
`endif
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] res,
    output logic             gate,
    output logic             strobe,
    output logic             store,
    output logic             sh_a,
    output logic             sh_b,
    output logic             clk_sh
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        STROBE = 3'd2,
        STORE  = 3'd3,
        SHIFT  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic [DIV_W-1:0] div_cnt;

    // Shadow copies of the frame configuration, frozen at start
    logic [CNT_W-1:0] gate_len_q;
    logic [CNT_W-1:0] strb_len_q;
    logic [CNT_W-1:0] shift_len_q;
    logic [DIV_W-1:0] clk_div_q;
    logic [1:0]       sh_sel_q;
    logic [7:0]       rep_cnt;

    logic [7:0]       repeat_in;
    logic             more_frames;

    // Counters hold "cycles remaining after this one", so a length L loads L-1;
    // a zero length behaves like a length of one.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : (len - CNT_ONE);
    endfunction

`ifdef PMC_PM_CTRL_SEQ_REPEAT_EN
    assign repeat_in = cfg_repeat;
`else
    assign repeat_in = 8'd0;
`endif

    // Another frame follows while the repeat counter is still non-zero
    assign more_frames = (rep_cnt != 8'd0);

    // Frame sequencer: state, counters, shadow config and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pulse_cnt   <= '0;
            div_cnt     <= '0;
            gate_len_q  <= '0;
            strb_len_q  <= '0;
            shift_len_q <= '0;
            clk_div_q   <= '0;
            sh_sel_q    <= '0;
            rep_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res         <= '0;
            gate        <= 1'b0;
            strobe      <= 1'b0;
            store       <= 1'b0;
            sh_a        <= 1'b0;
            sh_b        <= 1'b0;
            clk_sh      <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            state   <= IDLE;
            rep_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gate    <= 1'b0;
            strobe  <= 1'b0;
            store   <= 1'b0;
            sh_a    <= 1'b0;
            sh_b    <= 1'b0;
            clk_sh  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        gate_len_q  <= cfg_gate_len;
                        strb_len_q  <= cfg_strb_len;
                        shift_len_q <= cfg_shift_len;
                        clk_div_q   <= cfg_clk_div;
                        sh_sel_q    <= cfg_sh_sel;
                        rep_cnt     <= repeat_in;
                        res         <= cfg_res;
                        cnt         <= len_m1(cfg_gate_len);
                        state       <= GATE;
                        gate        <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                GATE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        gate <= 1'b0;
                        if (strb_len_q != '0) begin
                            state  <= STROBE;
                            strobe <= 1'b1;
                            cnt    <= len_m1(strb_len_q);
                        end else begin
                            state <= STORE;
                            store <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        strobe <= 1'b0;
                        state  <= STORE;
                        store  <= 1'b1;
                    end
                end
                STORE: begin
                    store <= 1'b0;
                    if (shift_len_q != '0) begin
                        state     <= SHIFT;
                        sh_a      <= sh_sel_q[1];
                        sh_b      <= sh_sel_q[0];
                        clk_sh    <= 1'b1;
                        div_cnt   <= clk_div_q;
                        pulse_cnt <= len_m1(shift_len_q);
                    end else if (more_frames) begin
                        state   <= GATE;
                        gate    <= 1'b1;
                        cnt     <= len_m1(gate_len_q);
                        rep_cnt <= rep_cnt - 8'd1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end else begin
                        div_cnt <= clk_div_q;
                        if (clk_sh) begin
                            clk_sh <= 1'b0;
                        end else if (pulse_cnt != '0) begin
                            clk_sh    <= 1'b1;
                            pulse_cnt <= pulse_cnt - CNT_ONE;
                        end else begin
                            sh_a <= 1'b0;
                            sh_b <= 1'b0;
                            if (more_frames) begin
                                state   <= GATE;
                                gate    <= 1'b1;
                                cnt     <= len_m1(gate_len_q);
                                rep_cnt <= rep_cnt - 8'd1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    gate   <= 1'b0;
                    strobe <= 1'b0;
                    store  <= 1'b0;
                    sh_a   <= 1'b0;
                    sh_b   <= 1'b0;
                    clk_sh <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmc_pm_ctrl_seq.sv
// tb_pmc_pm_ctrl_seq: scoreboard bench for the acquisition sequencer.
// Stimulus tasks push the per-cycle expected output bundle into a queue; a
// monitor pops one entry per cycle on the falling edge and compares.
module tb_pmc_pm_ctrl_seq;

    localparam int RES_W = 10;
    localparam int CNT_W = 16;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [RES_W-1:0] cfg_res = '0;
    logic [CNT_W-1:0] cfg_gate_len = '0;
    logic [CNT_W-1:0] cfg_strb_len = '0;
    logic [CNT_W-1:0] cfg_shift_len = '0;
    logic [DIV_W-1:0] cfg_clk_div = '0;
    logic [1:0]       cfg_sh_sel = '0;
`ifdef PMC_PM_CTRL_SEQ_REPEAT_EN
    logic [7:0]       cfg_repeat = '0;
`endif
    logic             busy, done, gate, strobe, store, sh_a, sh_b, clk_sh;
    logic [RES_W-1:0] res;

    pmc_pm_ctrl_seq #(.RES_W(RES_W), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_res(cfg_res), .cfg_gate_len(cfg_gate_len), .cfg_strb_len(cfg_strb_len),
        .cfg_shift_len(cfg_shift_len), .cfg_clk_div(cfg_clk_div), .cfg_sh_sel(cfg_sh_sel),
`ifdef PMC_PM_CTRL_SEQ_REPEAT_EN
        .cfg_repeat(cfg_repeat),
`endif
        .busy(busy), .done(done), .res(res), .gate(gate), .strobe(strobe),
        .store(store), .sh_a(sh_a), .sh_b(sh_b), .clk_sh(clk_sh)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             gate;
        logic             strobe;
        logic             store;
        logic             sh_a;
        logic             sh_b;
        logic             clk_sh;
        logic [RES_W-1:0] res;
    } exp_t;

    exp_t             exp_q[$];
    string            name_q[$];
    exp_t             tl[$];
    int               errors = 0;
    int               checks = 0;
    logic [RES_W-1:0] cur_res = '0;

    function automatic exp_t ent(input logic b, input logic d, input logic g, input logic s,
                                 input logic st, input logic a, input logic bb, input logic c,
                                 input logic [RES_W-1:0] r);
        exp_t e;
        e.busy = b; e.done = d; e.gate = g; e.strobe = s; e.store = st;
        e.sh_a = a; e.sh_b = bb; e.clk_sh = c; e.res = r;
        return e;
    endfunction

    function automatic exp_t idle(input logic [RES_W-1:0] r);
        return ent(0, 0, 0, 0, 0, 0, 0, 0, r);
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("busy=%b done=%b gate=%b strobe=%b store=%b sh_a=%b sh_b=%b clk_sh=%b res=%h",
                         e.busy, e.done, e.gate, e.strobe, e.store, e.sh_a, e.sh_b, e.clk_sh, e.res);
    endfunction

    // Expected per-cycle timeline of a frame, cycle 0 being the cycle start is driven
    task automatic build_frame(input int gl, input int sl, input int shl, input int dv,
                               input logic [1:0] sel, input logic [RES_W-1:0] r_old,
                               input logic [RES_W-1:0] r_new, input int reps);
        tl.delete();
        tl.push_back(idle(r_old));
        for (int f = 0; f <= reps; f++) begin
            for (int i = 0; i < ((gl == 0) ? 1 : gl); i++) tl.push_back(ent(1, 0, 1, 0, 0, 0, 0, 0, r_new));
            for (int i = 0; i < sl; i++) tl.push_back(ent(1, 0, 0, 1, 0, 0, 0, 0, r_new));
            tl.push_back(ent(1, 0, 0, 0, 1, 0, 0, 0, r_new));
            for (int p = 0; p < shl; p++) begin
                for (int k = 0; k <= dv; k++) tl.push_back(ent(1, 0, 0, 0, 0, sel[1], sel[0], 1, r_new));
                for (int k = 0; k <= dv; k++) tl.push_back(ent(1, 0, 0, 0, 0, sel[1], sel[0], 0, r_new));
            end
        end
        tl.push_back(ent(1, 1, 0, 0, 0, 0, 0, 0, r_new));
        tl.push_back(idle(r_new));
        tl.push_back(idle(r_new));
    endtask

    task automatic push_timeline(input string name);
        foreach (tl[i]) begin
            exp_q.push_back(tl[i]);
            name_q.push_back($sformatf("%s c%0d", name, i));
        end
    endtask

    // Bounded wait for the monitor to consume every pending expectation
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL %s drain timeout: pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        @(posedge clk);
    endtask

    // Runs one start request with optional abort, start-while-busy and cfg-change cycles
    task automatic apply_stimulus(input string name, input int gl, input int sl, input int shl,
                                  input int dv, input logic [1:0] sel, input logic [RES_W-1:0] r_new,
                                  input int reps, input int abort_at, input int busy_start_at,
                                  input int cfg_change_at);
        build_frame(gl, sl, shl, dv, sel, cur_res, r_new, reps);
        if (abort_at > 0) begin
            while (tl.size() > abort_at + 1) tl.delete(tl.size() - 1);
            for (int i = 0; i < 3; i++) tl.push_back(idle(r_new));
        end
        @(posedge clk);
        #2;
        push_timeline(name);
        cfg_res       = r_new;
        cfg_gate_len  = CNT_W'(gl);
        cfg_strb_len  = CNT_W'(sl);
        cfg_shift_len = CNT_W'(shl);
        cfg_clk_div   = DIV_W'(dv);
        cfg_sh_sel    = sel;
`ifdef PMC_PM_CTRL_SEQ_REPEAT_EN
        cfg_repeat    = 8'(reps);
`endif
        start = 1'b1;
        for (int t = 1; t < tl.size(); t++) begin
            @(posedge clk);
            #2;
            start = (t == busy_start_at);
            abort = (t == abort_at);
            if (t == cfg_change_at) begin
                cfg_res       = ~r_new;
                cfg_gate_len  = 16'd7;
                cfg_strb_len  = 16'd9;
                cfg_shift_len = 16'd5;
                cfg_clk_div   = 8'd4;
                cfg_sh_sel    = ~sel;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        cur_res = r_new;
        wait_drain(name);
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending
    initial begin : monitor
        exp_t  e, got;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                got = ent(busy, done, gate, strobe, store, sh_a, sh_b, clk_sh, res);
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("[TB] FAIL %s: got %s required %s", n, fmt(got), fmt(e));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Reset state
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(idle('0));
            name_q.push_back($sformatf("reset c%0d", i));
        end
        wait_drain("reset");
        rst = 1'b0;
        @(posedge clk);

        // Basic frame: gate 1-3, strobe 4-5, store 6, clk_sh high 7,9,11,13, done 15
        apply_stimulus("basic", 3, 2, 4, 0, 2'b10, 10'h2A5, 0, 0, 0, 0);
        // Zero lengths: gate 1, store 2, done 3
        apply_stimulus("zero_len", 0, 0, 0, 0, 2'b11, 10'h155, 0, 0, 0, 0);
        // Divider 2 with cfg scrambled mid-frame
        apply_stimulus("div2_cfgchg", 1, 1, 2, 2, 2'b11, 10'h3FF, 0, 0, 0, 3);
        // Abort during SHIFT, start attempted while busy
        apply_stimulus("abort_shift", 2, 1, 3, 1, 2'b01, 10'h0F0, 0, 8, 3, 0);

        // Start and abort together in IDLE: no frame
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(idle(cur_res));
            name_q.push_back($sformatf("start_abort c%0d", i));
        end
        cfg_gate_len = 16'd2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        abort = 1'b0;
        wait_drain("start_abort");

        // Async reset in the middle of GATE
        @(posedge clk);
        #2;
        exp_q.push_back(idle(cur_res));                      name_q.push_back("rst_gate c0");
        exp_q.push_back(ent(1, 0, 1, 0, 0, 0, 0, 0, 10'h2C3)); name_q.push_back("rst_gate c1");
        for (int i = 2; i < 5; i++) begin
            exp_q.push_back(idle('0));
            name_q.push_back($sformatf("rst_gate c%0d", i));
        end
        cfg_res = 10'h2C3; cfg_gate_len = 16'd5; cfg_strb_len = 16'd1;
        cfg_shift_len = 16'd1; cfg_clk_div = 8'd0; cfg_sh_sel = 2'b11;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cur_res = '0;
        wait_drain("rst_gate");

        // Normal frame after reset
        apply_stimulus("after_rst", 2, 0, 1, 0, 2'b01, 10'h011, 0, 0, 0, 0);

`ifdef PMC_PM_CTRL_SEQ_REPEAT_EN
        // Three back-to-back frames, one done
        apply_stimulus("repeat2", 2, 1, 1, 0, 2'b10, 10'h1E1, 2, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
